// File: rtl/uart_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_arb_pkg : shared defaults and FSM encoding for uart_rsp_arb   |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
package uart_arb_pkg;

  localparam int c_n_req_default   = 4;
  localparam int c_timeout_default = 4096;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t c_st_idle = 2'd0;
  localparam arb_state_t c_st_send = 2'd1;
  localparam arb_state_t c_st_ack  = 2'd2;
  localparam arb_state_t c_st_rel  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/uart_rsp_arb_rr_pick.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_pick : combinational round-robin pick, search starts after      |
// |           last_grant and wraps at P_N_REQ-1                        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int P_N_REQ = c_n_req_default,
  parameter int P_IDX_W = $clog2(P_N_REQ)
) (
  input  logic [P_N_REQ-1:0] req,
  input  logic [P_IDX_W-1:0] last_grant,
  output logic               valid,
  output logic [P_IDX_W-1:0] index
);

  int                 sum;
  logic [P_IDX_W-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest pending request wins.
  always_comb begin
    valid = |req;
    index = '0;
    sum   = 0;
    cand  = '0;
    for (int k = P_N_REQ; k >= 1; k--) begin
      sum = int'(last_grant) + k;
      if (sum >= P_N_REQ) sum = sum - P_N_REQ;
      cand = P_IDX_W'(sum);
      if (req[cand]) index = cand;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rsp_arb.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rsp_arb : round-robin arbiter of 4-phase byte requesters onto |
// |                one UART response handshake, with send timeout      |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
module uart_rsp_arb
  import uart_arb_pkg::*;
#(
  parameter int P_N_REQ   = c_n_req_default,
  parameter int P_TIMEOUT = c_timeout_default
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [P_N_REQ-1:0]         req,
  input  logic [8*P_N_REQ-1:0]       data,
  output logic [P_N_REQ-1:0]         ack,
  output logic                       rsp_req,
  input  logic                       rsp_ack,
  output logic [7:0]                 rsp_data,
  output logic [$clog2(P_N_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int                 c_idx_w    = $clog2(P_N_REQ);
  localparam int                 c_cnt_w    = $clog2(P_TIMEOUT);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(P_TIMEOUT - 1);
  localparam logic [c_idx_w-1:0] c_last_rst = c_idx_w'(P_N_REQ - 1);

  arb_state_t           state_q, state_d;
  logic [P_N_REQ-1:0]   req_seen_q, req_seen_d;
  logic [c_idx_w-1:0]   grant_q, grant_d;
  logic [c_idx_w-1:0]   last_grant_q, last_grant_d;
  logic [7:0]           byte_q, byte_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic                 timeout_err_q, timeout_err_d;
  logic                 pick_valid;
  logic [c_idx_w-1:0]   pick_index;
  logic                 send_expired;

  // A request is eligible once it has been high on two consecutive edges,
  // which gives the two-edge req-to-rsp_req latency and honours withdrawals.
  rr_pick #(
    .P_N_REQ (P_N_REQ),
    .P_IDX_W (c_idx_w)
  ) u_rr_pick (
    .req        (req & req_seen_q),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .index      (pick_index)
  );

  assign send_expired = (cnt_q == c_cnt_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= c_st_idle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle: if (pick_valid) state_d = c_st_send;
      c_st_send: if (rsp_ack || send_expired) state_d = c_st_ack;
      c_st_ack:  if (!req[grant_q]) state_d = c_st_rel;
      c_st_rel:  state_d = c_st_idle;
      default:   state_d = c_st_idle;
    endcase
  end

  always_comb begin
    rsp_req     = (state_q == c_st_send);
    busy        = (state_q != c_st_idle);
    ack         = '0;
    if (state_q == c_st_ack) ack[grant_q] = 1'b1;
    grant_id    = grant_q;
    rsp_data    = byte_q;
    timeout_err = timeout_err_q;
  end

  always_comb begin
    req_seen_d    = req;
    grant_d       = grant_q;
    byte_d        = byte_q;
    last_grant_d  = last_grant_q;
    cnt_d         = '0;
    timeout_err_d = 1'b0;
    if (state_q == c_st_idle && pick_valid) begin
      grant_d = pick_index;
      for (int i = 0; i < P_N_REQ; i++) begin
        if (pick_index == c_idx_w'(i)) byte_d = data[8*i +: 8];
      end
    end
    if (state_q == c_st_send) begin
      cnt_d         = cnt_q + 1'b1;
      timeout_err_d = send_expired && !rsp_ack;
    end
    if (state_q == c_st_rel) last_grant_d = grant_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_seen_q    <= '0;
      grant_q       <= '0;
      byte_q        <= '0;
      last_grant_q  <= c_last_rst;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      req_seen_q    <= req_seen_d;
      grant_q       <= grant_d;
      byte_q        <= byte_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rsp_arb.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_uart_rsp_arb : self-checking bench for uart_rsp_arb             |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
module tb_uart_rsp_arb;

  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] data;
  logic [N-1:0]   ack;
  logic           rsp_req;
  logic           rsp_ack;
  logic [7:0]     rsp_data;
  logic [1:0]     grant_id;
  logic           busy;
  logic           timeout_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  uart_rsp_arb #(
    .P_N_REQ   (N),
    .P_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .data        (data),
    .ack         (ack),
    .rsp_req     (rsp_req),
    .rsp_ack     (rsp_ack),
    .rsp_data    (rsp_data),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic [N-1:0] mask;
    logic [31:0]  word;
    int           m;
    int           exp_grant;
    logic [7:0]   exp_data;
    int           exp_hi;
    int           exp_to;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++) if (j == i) r[j] = 1'b1;
    return r;
  endfunction

  // Round-robin rule: first asserted requester after 'last', wrapping.
  function automatic int rr_model(input logic [N-1:0] mask, input int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (mask[i]) return i;
    end
    return -1;
  endfunction

  task automatic wait_rsp_req(input string name);
    int lat;
    lat = 0;
    do begin tick(); lat++; end while (!rsp_req && lat < 40);
    check(name, rsp_req, 1);
  endtask

  task automatic wait_ack(input string name);
    int c;
    c = 0;
    while (ack == '0 && c < 40) begin tick(); c++; end
    check(name, (ack != '0), 1);
  endtask

  task automatic run_vec(input int v);
    vec_t t;
    int   lat, k, hi, tmo;
    t       = vecs[v];
    req     = t.mask;
    data    = t.word;
    rsp_ack = 1'b0;
    lat     = 0;
    do begin tick(); lat++; end while (!rsp_req && lat < 8);
    check($sformatf("v%0d_latency", v), lat, 2);
    check($sformatf("v%0d_grant", v), grant_id, t.exp_grant);
    check($sformatf("v%0d_data", v), rsp_data, t.exp_data);
    k = 1; hi = 1; tmo = 0;
    while (ack == '0 && k < 40) begin
      rsp_ack = (k == t.m);
      tick();
      rsp_ack = 1'b0;
      k++;
      if (rsp_req) hi++;
      if (timeout_err) tmo++;
    end
    check($sformatf("v%0d_ack", v), ack, onehot(t.exp_grant));
    check($sformatf("v%0d_latched", v), {grant_id, rsp_data}, {2'(t.exp_grant), t.exp_data});
    for (int c = 0; c < 2; c++) begin
      tick();
      if (timeout_err) tmo++;
    end
    check($sformatf("v%0d_ack_held", v), ack, onehot(t.exp_grant));
    req     = '0;
    rsp_ack = 1'b1;
    tick();
    rsp_ack = 1'b0;
    if (timeout_err) tmo++;
    check($sformatf("v%0d_rel_ack", v), ack, 0);
    tick();
    if (timeout_err) tmo++;
    check($sformatf("v%0d_idle_busy", v), busy, 0);
    check($sformatf("v%0d_rsp_req_cycles", v), hi, t.exp_hi);
    check($sformatf("v%0d_timeout_pulses", v), tmo, t.exp_to);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int         idx, cyc, gap, min_gap, sc, bsy;
    int         k, m, hi, tmo, cur, last_m, n_done, viol;
    bit         prev, in_xfer;
    logic [7:0] bytes [N];
    int         dly [N];

    vecs[0] = '{4'b0100, 32'h11A52233, 10, 2, 8'hA5, 10, 0};
    vecs[1] = '{4'b1111, 32'h44332211,  3, 3, 8'h44,  3, 0};
    vecs[2] = '{4'b1111, 32'h44332211,  1, 0, 8'h11,  1, 0};
    vecs[3] = '{4'b1001, 32'h88776655,  2, 3, 8'h88,  2, 0};
    vecs[4] = '{4'b1001, 32'h88776655, 16, 0, 8'h55, 16, 0};
    vecs[5] = '{4'b0001, 32'h88776655,  0, 0, 8'h55, 16, 1};
    vecs[6] = '{4'b0110, 32'hDEADBEEF,  0, 1, 8'hBE, 16, 1};
    vecs[7] = '{4'b0110, 32'hDEADBEEF,  5, 2, 8'hAD,  5, 0};

    // Reset with requests pending: nothing may move.
    rst = 1'b1; req = '1; data = 32'hFFFFFFFF; rsp_ack = 1'b1;
    tick(); tick(); tick();
    check("rst_ack", ack, 0);
    check("rst_rsp_req", rsp_req, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    req = '0; data = '0; rsp_ack = 1'b0;
    rst = 1'b0;
    tick();

    // One-cycle request withdrawn before it can be granted.
    req = 4'b0010;
    tick();
    req = '0;
    bsy = 0;
    for (int c = 0; c < 4; c++) begin tick(); bsy |= int'(busy); end
    check("withdraw_no_grant", bsy, 0);

    for (int v = 0; v < 8; v++) run_vec(v);

    // Stray rsp_ack in IDLE, then data change after latching.
    rsp_ack = 1'b1;
    tick();
    rsp_ack = 1'b0;
    tick();
    check("stray_ack_idle", {busy, rsp_req}, 0);
    data = 32'h00000011;
    req  = 4'b0001;
    wait_rsp_req("dchg_send");
    check("dchg_grant", grant_id, 0);
    data[7:0] = 8'h22;
    tick(); tick(); tick();
    check("dchg_send_data", rsp_data, 8'h11);
    rsp_ack = 1'b1;
    tick();
    rsp_ack = 1'b0;
    wait_ack("dchg_ack");
    check("dchg_ack_data", rsp_data, 8'h11);
    req = '0;
    tick(); tick();

    // Reset in SEND aborts at once and restarts the pointer at requester 0.
    req  = 4'b1010;
    data = 32'h44332211;
    wait_rsp_req("mrst_send");
    check("mrst_pre_grant", grant_id, 1);
    #2 rst = 1'b1;
    #1 check("mrst_async_outputs", {rsp_req, busy, ack}, 0);
    tick();
    check("mrst_regs", {timeout_err, grant_id, rsp_data}, 0);
    rst = 1'b0;
    req = 4'b1111;
    wait_rsp_req("mrst_resend");
    check("mrst_next_grant", grant_id, 0);
    rsp_ack = 1'b1;
    tick();
    rsp_ack = 1'b0;
    wait_ack("mrst_ack");
    req = '0;
    tick(); tick();

    // Four requesters re-requesting continuously: strict rotation.
    rst = 1'b1; tick(); rst = 1'b0;
    req = '1; data = 32'h44332211;
    idx = 0; cyc = 0; gap = 0; min_gap = 99; sc = 0; prev = 1'b0;
    while (idx < 8 && cyc < 400) begin
      tick(); cyc++;
      if (rsp_req && !prev) begin
        check($sformatf("rot_order%0d", idx), grant_id, idx % N);
        if (idx > 0 && gap < min_gap) min_gap = gap;
        idx++;
        sc = 0;
      end
      if (rsp_req) begin sc++; gap = 0; end
      else gap++;
      rsp_ack = rsp_req && (sc == 2);
      for (int i = 0; i < N; i++) begin
        if (ack[i]) req[i] = 1'b0;
        else if (!req[i]) req[i] = 1'b1;
      end
      prev = rsp_req;
    end
    check("rot_transfers", idx, 8);
    check("rot_gap_ge2", (min_gap >= 2), 1);
    req = '0;
    for (int c = 0; c < 30; c++) begin rsp_ack = rsp_req; tick(); end
    rsp_ack = 1'b0;

    // Randomised traffic against the transaction-level model.
    rst = 1'b1; tick(); rst = 1'b0;
    req = '0; data = '0;
    last_m = N - 1; cur = -1; n_done = 0; viol = 0; cyc = 0;
    in_xfer = 1'b0; prev = 1'b0; k = 0; m = 0; hi = 0; tmo = 0;
    for (int i = 0; i < N; i++) begin bytes[i] = 8'h00; dly[i] = 0; end
    while (n_done < 40 && cyc < 20000) begin
      tick(); cyc++;
      if (rsp_req && !prev) begin
        cur = rr_model(req, last_m);
        check("rnd_grant", grant_id, cur);
        if (cur >= 0) begin
          check("rnd_data", rsp_data, bytes[cur]);
          last_m = cur;
        end else begin
          check("rnd_data", rsp_data, 256);
        end
        in_xfer = 1'b1; k = 1; hi = 1; tmo = 0;
        m = $urandom_range(1, 18);
      end else if (in_xfer) begin
        k++;
        if (rsp_req) hi++;
        if (timeout_err) tmo++;
        if (!busy) begin
          check("rnd_rsp_req_cycles", hi, (m > TO) ? TO : m);
          check("rnd_timeout_pulses", tmo, (m > TO) ? 1 : 0);
          in_xfer = 1'b0;
          n_done++;
        end
      end
      if ($countones(ack) > 1 || (ack != '0 && (!in_xfer || ack != onehot(cur)))) viol++;
      rsp_ack = in_xfer && (k == m);
      for (int i = 0; i < N; i++) begin
        if (req[i] && ack[i]) begin
          if (dly[i] == 0) req[i] = 1'b0;
          else dly[i]--;
        end
      end
      // New requests only while busy, or all together from a fully idle bus.
      if (busy || req == '0) begin
        for (int i = 0; i < N; i++) begin
          if (!req[i] && !ack[i] && $urandom_range(0, 2) == 0) begin
            bytes[i]       = 8'($urandom);
            data[8*i +: 8] = bytes[i];
            dly[i]         = $urandom_range(0, 3);
            req[i]         = 1'b1;
          end
        end
      end
      prev = rsp_req;
    end
    check("rnd_transfers", n_done, 40);
    check("rnd_ack_onehot", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
